// File: rtl/branch_predictor.sv
// Branch history table with target buffer: zero-latency lookup, ID-stage training, sequenced clear.
// Optional statistics counters are enabled by defining BRANCH_PREDICTOR_STATS_EN.
module branch_predictor #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned TAG_W   = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              pred_hit_o,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              clear_i,
  output logic              busy_o,
  output logic [31:0]       stat_upd_o,
  output logic [31:0]       stat_mispred_o
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned CtrWtInt = 1 << (CTR_W - 1);
  localparam int unsigned CtrWntInt = CtrWtInt - 1;
  localparam logic [CTR_W-1:0] CtrWt  = CtrWtInt[CTR_W-1:0];
  localparam logic [CTR_W-1:0] CtrWnt = CtrWntInt[CTR_W-1:0];
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(ENTRIES - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;

  logic              valid_q [ENTRIES];
  logic [TAG_W-1:0]  tag_q   [ENTRIES];
  logic [CTR_W-1:0]  ctr_q   [ENTRIES];
  logic [ADDR_W-1:0] tgt_q   [ENTRIES];

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             lk_hit, upd_hit, upd_acc;
  logic [CTR_W-1:0] ctr_upd;
  logic             unused_pc_bits;

  assign lk_idx  = pc_i[IDX_W+1:2];
  assign lk_tag  = pc_i[IDX_W+1+TAG_W:IDX_W+2];
  assign upd_idx = upd_pc_i[IDX_W+1:2];
  assign upd_tag = upd_pc_i[IDX_W+1+TAG_W:IDX_W+2];

  // Bits outside index/tag do not participate in the lookup.
  assign unused_pc_bits = ^{pc_i, upd_pc_i};

  assign busy_o        = (state_q == StClear);
  assign lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) && !busy_o;
  assign pred_hit_o    = lk_hit;
  assign pred_taken_o  = lk_hit && ctr_q[lk_idx][CTR_W-1];
  assign pred_target_o = pred_taken_o ? tgt_q[lk_idx] : pc_i + ADDR_W'(4);

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_acc = upd_valid_i && (state_q == StIdle);

  always_comb begin
    ctr_upd = ctr_q[upd_idx];
    if (upd_taken_i) begin
      if (ctr_q[upd_idx] != '1) ctr_upd = ctr_q[upd_idx] + CTR_W'(1);
    end else begin
      if (ctr_q[upd_idx] != '0) ctr_upd = ctr_q[upd_idx] - CTR_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    unique case (state_q)
      StIdle: begin
        if (clear_i) begin
          state_d = StClear;
          sweep_d = '0;
        end
      end
      StClear: begin
        sweep_d = sweep_q + IDX_W'(1);
        if (sweep_q == LastIdx) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        ctr_q[i]   <= CtrWnt;
        tgt_q[i]   <= '0;
      end
    end else if (state_q == StClear) begin
      valid_q[sweep_q] <= 1'b0;
      tag_q[sweep_q]   <= '0;
      ctr_q[sweep_q]   <= CtrWnt;
      tgt_q[sweep_q]   <= '0;
    end else if (upd_valid_i) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= ctr_upd;
        if (upd_taken_i) tgt_q[upd_idx] <= upd_target_i;
      end else if (upd_taken_i) begin
        // Direct-mapped: a taken miss evicts whatever occupies the slot.
        valid_q[upd_idx] <= 1'b1;
        tag_q[upd_idx]   <= upd_tag;
        ctr_q[upd_idx]   <= CtrWt;
        tgt_q[upd_idx]   <= upd_target_i;
      end
    end
  end

`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] stat_upd_q, stat_upd_d;
  logic [31:0] stat_mis_q, stat_mis_d;
  logic        upd_pred_taken, upd_mispred;

  assign upd_pred_taken = upd_hit && ctr_q[upd_idx][CTR_W-1];
  assign upd_mispred    = (upd_pred_taken != upd_taken_i) ||
                          (upd_pred_taken && (tgt_q[upd_idx] != upd_target_i));

  always_comb begin
    stat_upd_d = stat_upd_q;
    stat_mis_d = stat_mis_q;
    if ((state_q == StIdle) && clear_i) begin
      stat_upd_d = '0;
      stat_mis_d = '0;
    end else if (upd_acc) begin
      if (stat_upd_q != '1) stat_upd_d = stat_upd_q + 32'd1;
      if (upd_mispred && (stat_mis_q != '1)) stat_mis_d = stat_mis_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stat_upd_q <= '0;
      stat_mis_q <= '0;
    end else begin
      stat_upd_q <= stat_upd_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign stat_upd_o     = stat_upd_q;
  assign stat_mispred_o = stat_mis_q;
`else
  logic unused_upd_acc;
  assign unused_upd_acc = upd_acc;
  assign stat_upd_o     = '0;
  assign stat_mispred_o = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES=64, CTR_W=2, TAG_W=8).
module tb_branch_predictor;

`ifdef BRANCH_PREDICTOR_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pc_i;
  logic        pred_hit_o, pred_taken_o;
  logic [31:0] pred_target_o;
  logic        upd_valid_i, upd_taken_i;
  logic [31:0] upd_pc_i, upd_target_i;
  logic        clear_i, busy_o;
  logic [31:0] stat_upd_o, stat_mispred_o;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  branch_predictor #(
    .ADDR_W (32),
    .ENTRIES(64),
    .CTR_W  (2),
    .TAG_W  (8)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .pc_i          (pc_i),
    .pred_hit_o    (pred_hit_o),
    .pred_taken_o  (pred_taken_o),
    .pred_target_o (pred_target_o),
    .upd_valid_i   (upd_valid_i),
    .upd_pc_i      (upd_pc_i),
    .upd_taken_i   (upd_taken_i),
    .upd_target_i  (upd_target_i),
    .clear_i       (clear_i),
    .busy_o        (busy_o),
    .stat_upd_o    (stat_upd_o),
    .stat_mispred_o(stat_mispred_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present an update for one rising edge, return at the following falling edge.
  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    @(negedge clk_i);
    upd_valid_i  = 1'b1;
    upd_pc_i     = pc;
    upd_taken_i  = taken;
    upd_target_i = tgt;
    @(negedge clk_i);
    upd_valid_i  = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                      input logic taken, input logic [31:0] tgt);
    pc_i = pc;
    #1;
    check({tag, ".hit"}, {31'd0, pred_hit_o}, {31'd0, hit});
    check({tag, ".taken"}, {31'd0, pred_taken_o}, {31'd0, taken});
    check({tag, ".target"}, pred_target_o, tgt);
  endtask

  task automatic stats(input string tag, input logic [31:0] exp_upd, input logic [31:0] exp_mis);
    check({tag, ".stat_upd"}, stat_upd_o, StatsEn ? exp_upd : 32'd0);
    check({tag, ".stat_mis"}, stat_mispred_o, StatsEn ? exp_mis : 32'd0);
  endtask

  initial begin
    int busy_cnt;
    rst_i        = 1'b0;
    pc_i         = 32'h0;
    upd_valid_i  = 1'b0;
    upd_pc_i     = 32'h0;
    upd_taken_i  = 1'b0;
    upd_target_i = 32'h0;
    clear_i      = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;

    // Reset state
    look("rst", 32'h40, 1'b0, 1'b0, 32'h44);
    check("rst.busy", {31'd0, busy_o}, 32'd0);
    stats("rst", 32'd0, 32'd0);

    // Allocate 0x100 taken -> ctr 10
    upd(32'h100, 1'b1, 32'h200);
    look("alloc", 32'h100, 1'b1, 1'b1, 32'h200);

    // Two not-taken -> ctr 00
    upd(32'h100, 1'b0, 32'h0);
    look("nt1", 32'h100, 1'b1, 1'b0, 32'h104);
    upd(32'h100, 1'b0, 32'h0);
    look("nt2", 32'h100, 1'b1, 1'b0, 32'h104);

    // Four taken -> saturate 11, then one not-taken -> 10
    repeat (4) upd(32'h100, 1'b1, 32'h200);
    look("sat", 32'h100, 1'b1, 1'b1, 32'h200);
    upd(32'h100, 1'b0, 32'h0);
    look("sat_nt", 32'h100, 1'b1, 1'b1, 32'h200);

    // Alias: 0x1100 shares index 0 with 0x100, tag 0x11 evicts tag 0x01
    upd(32'h1100, 1'b1, 32'h300);
    look("alias_old", 32'h100, 1'b0, 1'b0, 32'h104);
    look("alias_new", 32'h1100, 1'b1, 1'b1, 32'h300);
    upd(32'h2200, 1'b0, 32'h0);
    look("nt_miss", 32'h2200, 1'b0, 1'b0, 32'h2204);
    look("nt_keep", 32'h1100, 1'b1, 1'b1, 32'h300);

    upd(32'h48, 1'b1, 32'h80);
    look("e18", 32'h48, 1'b1, 1'b1, 32'h80);
    // 11 accepted updates; mispredicts: alloc, nt1, T@00, T@01, NT@11, 0x1100, 0x48
    stats("pre_clr", 32'd11, 32'd7);

    // Clear sweep; an update to an already-swept index in cycle 5 must be ignored
    @(negedge clk_i);
    clear_i  = 1'b1;
    busy_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk_i);
      clear_i     = 1'b0;
      upd_valid_i = 1'b0;
      #1;
      if (!busy_o) break;
      busy_cnt++;
      if (busy_cnt == 2) look("busy_lk", 32'h1100, 1'b0, 1'b0, 32'h1104);
      if (busy_cnt == 5) begin
        upd_valid_i  = 1'b1;
        upd_pc_i     = 32'h4;
        upd_taken_i  = 1'b1;
        upd_target_i = 32'h500;
      end
    end
    check("busy_cycles", busy_cnt, 32'd64);
    look("clr_a", 32'h1100, 1'b0, 1'b0, 32'h1104);
    look("clr_b", 32'h48, 1'b0, 1'b0, 32'h4c);
    look("clr_c", 32'h4, 1'b0, 1'b0, 32'h8);
    stats("post_clr", 32'd0, 32'd0);

    // Reset asserted in sweep cycle 10
    upd(32'h100, 1'b1, 32'h200);
    look("retrain", 32'h100, 1'b1, 1'b1, 32'h200);
    @(negedge clk_i);
    clear_i  = 1'b1;
    busy_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk_i);
      clear_i = 1'b0;
      #1;
      if (busy_o) busy_cnt++;
      if (busy_cnt == 10 || !busy_o) break;
    end
    check("mid_cnt", busy_cnt, 32'd10);
    rst_i = 1'b0;
    #1;
    check("mid_rst.busy", {31'd0, busy_o}, 32'd0);
    look("mid_rst", 32'h100, 1'b0, 1'b0, 32'h104);
    stats("mid_rst", 32'd0, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    upd(32'h100, 1'b1, 32'h600);
    look("post_rst", 32'h100, 1'b1, 1'b1, 32'h600);
    check("post_rst.busy", {31'd0, busy_o}, 32'd0);
    stats("post_rst", 32'd1, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
